// File: rtl/sg_cfg_ctrl.sv
// rtl/sg_cfg_ctrl.sv - sync-generator timing reconfiguration sequencer with frame watchdog
// New timing words are latched into shadows and only applied on a VSYNC_ref falling edge.
module sg_cfg_ctrl #(
    parameter int VS_TIMEOUT   = 2000000,
    parameter int SETTLE_LINES = 4
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        VSYNC_ref,
    input  logic        HSYNC_ref,
    input  logic        cfg_req,
    input  logic [31:0] cfg_h_info,
    input  logic [31:0] cfg_v_info,
    input  logic [31:0] cfg_x_info,
    output logic [31:0] h_info,
    output logic [31:0] v_info,
    output logic [31:0] x_info,
    output logic        sg_reset_n,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        no_sync
);

    localparam int              WD_W      = $clog2(VS_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(VS_TIMEOUT);
    localparam logic [7:0]      LINE_LAST = 8'(SETTLE_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_APPLY,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;

    logic            r_vs_prev;
    logic            r_hs_prev;
    logic            w_vs_fall;
    logic            w_hs_fall;

    logic [WD_W-1:0] r_watchdog;
    logic [WD_W-1:0] w_watchdog_nx;
    logic            r_no_sync;

    logic [31:0]     r_sh_h;
    logic [31:0]     r_sh_v;
    logic [31:0]     r_sh_x;
    logic [31:0]     r_h_info;
    logic [31:0]     r_v_info;
    logic [31:0]     r_x_info;
    logic            r_pending;
    logic            r_valid;

    logic [7:0]      r_line_cnt;
    logic            r_sg_reset_n;
    logic            w_sg_reset_n_nx;
    logic            r_cfg_done;
    logic            w_cfg_done_nx;
    logic            w_apply;

    assign w_vs_fall = r_vs_prev & ~VSYNC_ref;
    assign w_hs_fall = r_hs_prev & ~HSYNC_ref;

    always_comb begin
        w_watchdog_nx = r_watchdog;
        if (w_vs_fall) begin
            w_watchdog_nx = '0;
        end else if (r_watchdog != WD_MAX) begin
            w_watchdog_nx = r_watchdog + WD_W'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_vs_prev  <= 1'b1;
            r_hs_prev  <= 1'b1;
            r_watchdog <= WD_MAX;
            r_no_sync  <= 1'b1;
        end else begin
            r_vs_prev  <= VSYNC_ref;
            r_hs_prev  <= HSYNC_ref;
            r_watchdog <= w_watchdog_nx;
            r_no_sync  <= (w_watchdog_nx == WD_MAX);
        end
    end

    // Sync loss outranks every other transition and parks the generator in reset.
    always_comb begin
        w_state_nx      = r_state;
        w_sg_reset_n_nx = r_sg_reset_n;
        w_cfg_done_nx   = 1'b0;
        w_apply         = 1'b0;
        if ((r_state != S_IDLE) && r_no_sync) begin
            w_state_nx      = S_IDLE;
            w_sg_reset_n_nx = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sg_reset_n_nx = 1'b0;
                    if (!r_no_sync && (r_pending || r_valid)) begin
                        w_state_nx = S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (w_vs_fall) begin
                        w_state_nx = S_APPLY;
                    end
                end
                S_APPLY: begin
                    w_sg_reset_n_nx = 1'b0;
                    w_apply         = 1'b1;
                    w_state_nx      = S_SETTLE;
                end
                S_SETTLE: begin
                    w_sg_reset_n_nx = 1'b0;
                    if (w_hs_fall && (r_line_cnt == LINE_LAST)) begin
                        w_state_nx      = S_RUN;
                        w_sg_reset_n_nx = 1'b1;
                        w_cfg_done_nx   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_pending) begin
                        w_state_nx = S_WAIT_VS;
                    end
                end
                default: begin
                    w_state_nx      = S_IDLE;
                    w_sg_reset_n_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sg_reset_n <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_line_cnt   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_sg_reset_n <= w_sg_reset_n_nx;
            r_cfg_done   <= w_cfg_done_nx;
            if (w_apply) begin
                r_line_cnt <= '0;
            end else if ((r_state == S_SETTLE) && w_hs_fall) begin
                r_line_cnt <= r_line_cnt + 8'd1;
            end
        end
    end

    // APPLY copies the shadows as they stood before any request landing in that same cycle.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_sh_h    <= '0;
            r_sh_v    <= '0;
            r_sh_x    <= '0;
            r_h_info  <= '0;
            r_v_info  <= '0;
            r_x_info  <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (cfg_req) begin
                r_sh_h <= cfg_h_info;
                r_sh_v <= cfg_v_info;
                r_sh_x <= cfg_x_info;
            end
            if (w_apply && r_pending) begin
                r_h_info <= r_sh_h;
                r_v_info <= r_sh_v;
                r_x_info <= r_sh_x;
                r_valid  <= 1'b1;
            end
            if (cfg_req) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign h_info     = r_h_info;
    assign v_info     = r_v_info;
    assign x_info     = r_x_info;
    assign sg_reset_n = r_sg_reset_n;
    assign cfg_done   = r_cfg_done;
    assign no_sync    = r_no_sync;
    assign cfg_busy   = r_pending | (r_state == S_WAIT_VS) | (r_state == S_APPLY)
                      | (r_state == S_SETTLE);

endmodule

// File: tb/tb_sg_cfg_ctrl.sv
// tb/tb_sg_cfg_ctrl.sv - directed self-checking bench for sg_cfg_ctrl
module tb_sg_cfg_ctrl;

    logic        PCLK = 1'b0;
    logic        reset;
    logic        VSYNC_ref;
    logic        HSYNC_ref;
    logic        cfg_req;
    logic [31:0] cfg_h_info;
    logic [31:0] cfg_v_info;
    logic [31:0] cfg_x_info;
    logic [31:0] h_info;
    logic [31:0] v_info;
    logic [31:0] x_info;
    logic        sg_reset_n;
    logic        cfg_busy;
    logic        cfg_done;
    logic        no_sync;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_vs_cyc = 0;
    int done_cnt = 0;
    int n = 0;
    int d0;
    bit vs_en = 1'b1;
    bit hs_new, vs_new;
    bit hs_prev_m = 1'b1;
    bit vs_prev_m = 1'b1;
    bit tb_hs_fall = 1'b0;
    bit tb_vs_fall = 1'b0;
    bit ok;
    bit bad;

    sg_cfg_ctrl #(
        .VS_TIMEOUT  (100),
        .SETTLE_LINES(2)
    ) dut (
        .PCLK      (PCLK),
        .reset     (reset),
        .VSYNC_ref (VSYNC_ref),
        .HSYNC_ref (HSYNC_ref),
        .cfg_req   (cfg_req),
        .cfg_h_info(cfg_h_info),
        .cfg_v_info(cfg_v_info),
        .cfg_x_info(cfg_x_info),
        .h_info    (h_info),
        .v_info    (v_info),
        .x_info    (x_info),
        .sg_reset_n(sg_reset_n),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .no_sync   (no_sync)
    );

    always #5 PCLK = ~PCLK;

    // hsync: 10-clock period, low 2; vsync: 60-clock period, low 3; falls tracked as the DUT sees them
    initial begin
        VSYNC_ref = 1'b1;
        HSYNC_ref = 1'b1;
        forever begin
            @(negedge PCLK);
            hs_new     = ((n % 10) >= 2);
            vs_new     = vs_en ? ((n % 60) >= 3) : 1'b1;
            tb_hs_fall = hs_prev_m & ~hs_new & ~reset;
            tb_vs_fall = vs_prev_m & ~vs_new & ~reset;
            hs_prev_m  = reset ? 1'b1 : hs_new;
            vs_prev_m  = reset ? 1'b1 : vs_new;
            HSYNC_ref  = hs_new;
            VSYNC_ref  = vs_new;
            n++;
        end
    end

    always @(negedge PCLK) begin
        if (cfg_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
        if (tb_vs_fall) last_vs_cyc = cyc;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_vs_fall(output bit found);
        found = 1'b0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (tb_vs_fall) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_hs_falls(input int cnt, output bit found);
        int seen;
        seen  = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tb_hs_fall) seen++;
            if (seen == cnt) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_req(input logic [31:0] h, input logic [31:0] v, input logic [31:0] x);
        cfg_req    = 1'b1;
        cfg_h_info = h;
        cfg_v_info = v;
        cfg_x_info = x;
        tick();
        cfg_req    = 1'b0;
    endtask

    task automatic chk_info(input string tag, input logic [31:0] h, input logic [31:0] v,
                            input logic [31:0] x);
        chk32({tag, "_h"}, h_info, h);
        chk32({tag, "_v"}, v_info, v);
        chk32({tag, "_x"}, x_info, x);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_req    = 1'b0;
        cfg_h_info = '0;
        cfg_v_info = '0;
        cfg_x_info = '0;
        repeat (6) tick();
        chk_info("rst", 32'h0, 32'h0, 32'h0);
        chk1("rst_sg_reset_n", sg_reset_n, 1'b0);
        chk1("rst_busy", cfg_busy, 1'b0);
        chk1("rst_done", cfg_done, 1'b0);
        chk1("rst_no_sync", no_sync, 1'b1);
        reset = 1'b0;

        // 1: power-up, no request
        bad = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tb_vs_fall) begin
                ok = 1'b1;
                break;
            end
            if (no_sync !== 1'b1) bad = 1'b1;
        end
        chk1("t1_vs_seen", ok, 1'b1);
        chk1("t1_no_sync_held_before_fall", bad, 1'b0);
        chk1("t1_no_sync_clear", no_sync, 1'b0);
        repeat (10) tick();
        chk1("t1_sg_reset_n", sg_reset_n, 1'b0);
        chk1("t1_busy", cfg_busy, 1'b0);
        chk32("t1_done_cnt", 32'(done_cnt), 32'd0);

        // 2: first configuration
        send_req(32'h12345678, 32'h0000ABCD, 32'h80000001);
        chk1("t2_busy", cfg_busy, 1'b1);
        chk32("t2_h_pre", h_info, 32'h0);
        wait_vs_fall(ok);
        chk1("t2_vs_seen", ok, 1'b1);
        chk32("t2_h_in_apply", h_info, 32'h0);
        tick();
        chk_info("t2_applied", 32'h12345678, 32'h0000ABCD, 32'h80000001);
        chk1("t2_sg_reset_n_apply", sg_reset_n, 1'b0);
        wait_hs_falls(1, ok);
        chk1("t2_hs1_seen", ok, 1'b1);
        chk1("t2_sg_reset_n_hs1", sg_reset_n, 1'b0);
        chk1("t2_done_hs1", cfg_done, 1'b0);
        wait_hs_falls(1, ok);
        chk1("t2_hs2_seen", ok, 1'b1);
        chk1("t2_sg_reset_n_run", sg_reset_n, 1'b1);
        chk1("t2_done_run", cfg_done, 1'b1);
        tick();
        chk1("t2_done_pulse_end", cfg_done, 1'b0);
        chk1("t2_busy_end", cfg_busy, 1'b0);

        // 3: back-to-back requests in RUN, last one wins
        d0 = done_cnt;
        send_req(32'h1, 32'hA, 32'hB);
        repeat (4) tick();
        send_req(32'h2, 32'h20, 32'h30);
        wait_vs_fall(ok);
        chk1("t3_vs_seen", ok, 1'b1);
        chk1("t3_sg_reset_n_live", sg_reset_n, 1'b1);
        chk32("t3_h_in_apply", h_info, 32'h12345678);
        tick();
        chk_info("t3_applied", 32'h2, 32'h20, 32'h30);
        chk1("t3_sg_reset_n_apply", sg_reset_n, 1'b0);
        wait_hs_falls(2, ok);
        chk1("t3_hs_seen", ok, 1'b1);
        chk1("t3_done_run", cfg_done, 1'b1);
        chk1("t3_sg_reset_n_run", sg_reset_n, 1'b1);
        repeat (20) tick();
        chk32("t3_one_sequence", 32'(done_cnt - d0), 32'd1);
        chk1("t3_busy_end", cfg_busy, 1'b0);
        chk32("t3_h_stable", h_info, 32'h2);

        // 4: request in the APPLY cycle stays pending
        send_req(32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
        wait_vs_fall(ok);
        chk1("t4_vs_seen", ok, 1'b1);
        send_req(32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003);
        chk_info("t4_old_shadow", 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
        chk1("t4_busy_pending", cfg_busy, 1'b1);
        wait_hs_falls(2, ok);
        chk1("t4_hs_seen", ok, 1'b1);
        chk1("t4_done_run", cfg_done, 1'b1);
        chk1("t4_sg_reset_n_run", sg_reset_n, 1'b1);
        tick();
        chk1("t4_busy_wait", cfg_busy, 1'b1);
        chk1("t4_sg_reset_n_wait", sg_reset_n, 1'b1);
        wait_vs_fall(ok);
        chk1("t4_vs2_seen", ok, 1'b1);
        chk32("t4_h_before_2nd", h_info, 32'hAAAA0001);
        tick();
        chk_info("t4_new_shadow", 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003);
        chk1("t4_sg_reset_n_apply2", sg_reset_n, 1'b0);
        wait_hs_falls(2, ok);
        chk1("t4_hs2_seen", ok, 1'b1);
        chk1("t4_done_run2", cfg_done, 1'b1);
        tick();
        chk1("t4_busy_end", cfg_busy, 1'b0);

        // 5: vsync loss in RUN, then reacquire
        d0    = done_cnt;
        vs_en = 1'b0;
        while (cyc < last_vs_cyc + 99) tick();
        chk1("t5_no_sync_wd99", no_sync, 1'b0);
        tick();
        chk1("t5_no_sync_wd100", no_sync, 1'b1);
        chk1("t5_sg_reset_n_still", sg_reset_n, 1'b1);
        tick();
        chk1("t5_sg_reset_n_parked", sg_reset_n, 1'b0);
        chk1("t5_busy_idle", cfg_busy, 1'b0);
        chk_info("t5_hold", 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003);
        while (cyc < last_vs_cyc + 141) tick();
        vs_en = 1'b1;
        wait_vs_fall(ok);
        chk1("t5_vs_back", ok, 1'b1);
        chk1("t5_no_sync_clear", no_sync, 1'b0);
        chk1("t5_sg_reset_n_idle", sg_reset_n, 1'b0);
        wait_vs_fall(ok);
        chk1("t5_vs_apply", ok, 1'b1);
        tick();
        chk_info("t5_reacq", 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003);
        chk1("t5_sg_reset_n_apply", sg_reset_n, 1'b0);
        wait_hs_falls(2, ok);
        chk1("t5_hs_seen", ok, 1'b1);
        chk1("t5_done_run", cfg_done, 1'b1);
        chk1("t5_sg_reset_n_run", sg_reset_n, 1'b1);
        tick();
        chk32("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk32("t5_h_unchanged", h_info, 32'hBBBB0001);

        // 6: reset during SETTLE
        repeat (18) tick();
        send_req(32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
        wait_vs_fall(ok);
        chk1("t6_vs_seen", ok, 1'b1);
        tick();
        chk32("t6_h_applied", h_info, 32'hCAFE0001);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_info("t6_rst", 32'h0, 32'h0, 32'h0);
        chk1("t6_sg_reset_n", sg_reset_n, 1'b0);
        chk1("t6_done", cfg_done, 1'b0);
        chk1("t6_busy", cfg_busy, 1'b0);
        chk1("t6_no_sync", no_sync, 1'b1);
        reset = 1'b0;
        wait_vs_fall(ok);
        chk1("t6_vs_seen2", ok, 1'b1);
        repeat (5) tick();
        chk1("t6_no_sync_clear", no_sync, 1'b0);
        chk1("t6_idle_busy", cfg_busy, 1'b0);
        chk1("t6_idle_sg_reset_n", sg_reset_n, 1'b0);
        chk32("t6_h_zero", h_info, 32'h0);
        chk32("total_done_cnt", 32'(done_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sg_cfg_ctrl.md
Name: sg_cfg_ctrl

Overview:
- Sequences timing reconfiguration of the output sync generator in the PCLK_SI domain.
- Captures new h/v/x timing words from the CPU-side PIOs (already synchronized) into shadow registers.
- Holds the sync generator in reset and applies the shadow registers only on a VSYNC_ref falling edge, then releases reset after a settle period of HSYNC_ref lines.
- A frame watchdog detects loss of the input sync and parks the sync generator in reset until sync returns.

Parameters:
- VS_TIMEOUT, 2000000: PCLK cycles without a VSYNC_ref falling edge before no_sync asserts; the counter width is clog2(VS_TIMEOUT+1).
- SETTLE_LINES, 4: HSYNC_ref falling edges counted after apply before sg_reset_n releases; range 1..255.

Ports:
- PCLK  in  1  sync-generator pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- VSYNC_ref  in  1  input vsync, active-low, already synchronized to PCLK.
- HSYNC_ref  in  1  input hsync, active-low, already synchronized to PCLK.
- cfg_req  in  1  one-cycle strobe; cfg_* words are sampled in this cycle.
- cfg_h_info  in  32  new horizontal timing word.
- cfg_v_info  in  32  new vertical timing word.
- cfg_x_info  in  32  new extra timing word.
- h_info  out  32  applied horizontal word, to the sync generator.
- v_info  out  32  applied vertical word.
- x_info  out  32  applied extra word.
- sg_reset_n  out  1  sync generator reset, active-low, registered.
- cfg_busy  out  1  a request is pending or an apply/settle is in progress.
- cfg_done  out  1  one-cycle pulse on entry to RUN.
- no_sync  out  1  watchdog expired (no input frames).

Behaviour:
- Reset values:
  - state=IDLE.
  - h_info, v_info, x_info, and the shadow registers = 0.
  - pending=0, valid=0.
  - sg_reset_n=0, cfg_done=0, cfg_busy=0.
  - watchdog=VS_TIMEOUT, so no_sync=1.
- Edge detect:
  - vs_fall = vs_prev & ~VSYNC_ref. hs_fall is formed the same way.
  - The prev registers reset to 1.
  - Each edge is seen in the same cycle the input is sampled low after being high.
- Watchdog:
  - Cleared to 0 on vs_fall; otherwise increments and saturates at VS_TIMEOUT.
  - no_sync = (watchdog == VS_TIMEOUT), registered; it deasserts the cycle after the first vs_fall.
- Request capture:
  - When cfg_req=1, the shadow registers load the cfg_* words and pending is set to 1, in any state, including during reset release.
  - Back-to-back requests: the last one wins.
  - A request arriving in the APPLY cycle stays pending; APPLY copies the shadow contents from before that request.
- cfg_busy = pending | (state is WAIT_VS, APPLY or SETTLE).
- State machine:
  - IDLE: sg_reset_n=0. Go to WAIT_VS when !no_sync & (pending | valid).
  - WAIT_VS:
    - sg_reset_n holds its current value, so video keeps running during a live reconfig until the frame edge.
    - On vs_fall, go to APPLY.
  - APPLY (1 cycle):
    - sg_reset_n=0.
    - If pending: h/v/x_info take the shadow values, pending=0, valid=1.
    - Line counter cleared. Go to SETTLE.
  - SETTLE:
    - Line counter increments on hs_fall.
    - When the counter reaches SETTLE_LINES: go to RUN, with sg_reset_n=1 and cfg_done=1 in the RUN entry cycle.
  - RUN: if pending, go to WAIT_VS.
- Sync loss:
  - In any state other than IDLE, no_sync=1 forces IDLE and sg_reset_n=0 on the next cycle.
  - This has priority over every other transition.
  - pending and the shadow registers are preserved.
  - h/v/x_info keep their last applied values.
- Reacquire:
  - From IDLE with valid=1 and pending=0, the block goes through WAIT_VS, APPLY, SETTLE to RUN without changing h/v/x_info.
  - cfg_done still pulses on entry to RUN.
- Outputs h/v/x_info change only in the APPLY cycle and are otherwise stable.
- reset asserted mid-operation returns every register to its reset value on the next PCLK edge.

Test Plan:
Bench parameters: VS_TIMEOUT=100, SETTLE_LINES=2, hsync period 10 clocks, vsync period 60 clocks.
1. Power-up, syncs running, no cfg_req -> no_sync=1 until the first vs_fall, then 0; state stays IDLE; sg_reset_n=0; cfg_done never pulses.
2. cfg_req with h=0x12345678, v=0x0000ABCD, x=0x80000001 -> cfg_busy=1 next cycle; h/v/x_info update exactly one cycle after the next vs_fall; sg_reset_n rises on the 2nd hs_fall after apply, together with a single cfg_done pulse; cfg_busy=0 afterwards.
3. In RUN, two cfg_req strobes 5 cycles apart (h=0x1, then h=0x2) -> only h=0x2 is applied; exactly one apply/settle sequence occurs; sg_reset_n stays 1 until the APPLY cycle.
4. cfg_req exactly in the APPLY cycle -> the old shadow is applied, pending stays 1; after RUN entry (cfg_done) the block returns to WAIT_VS and applies the new value on the following frame.
5. Hold VSYNC_ref high for 120 clocks while in RUN -> no_sync=1 at watchdog=100; sg_reset_n=0 the next cycle; h/v/x_info unchanged. Restart vsync -> reacquire sequence runs, cfg_done pulses, h/v/x_info still unchanged.
6. Assert reset during SETTLE -> the next cycle shows all outputs at their reset values, with no_sync=1 and state IDLE.
